// File: rtl/mips_cache_pkg.sv
// Types shared by the cache controller and its posted-write buffer.
package mips_cache_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1
   } wb_state_t;

   typedef struct packed {
      logic [31:2] addr;
      logic [31:0] data;
      logic [3:0]  byteenable;
   } wb_entry_t;

endpackage

// File: rtl/mips_cache_wbuf_match.sv
// Combinational DEPTH-way word-address comparator for the write buffer:
// any-valid-entry hit plus the hit on the newest entry.
module mips_cache_wbuf_match #(
   parameter int DEPTH = 4
) (
   input  logic [29:0]                   req_addr,
   input  logic [DEPTH-1:0][29:0]        entry_addr,
   input  logic [DEPTH-1:0]              valid,
   input  logic [$clog2(DEPTH)-1:0]      newest,
   output logic                          hit,
   output logic                          newest_hit
);

   logic [DEPTH-1:0] match;

   always_comb begin
      match = '0;
      for (int i = 0; i < DEPTH; i++) begin
         match[i] = valid[i] && (entry_addr[i] == req_addr);
      end
   end

   assign hit        = |match;
   assign newest_hit = match[newest];

endmodule

// File: rtl/mips_cache_wbuf_fifo.sv
// Posted-write FIFO between the CPU data port and the Avalon bus.
// Optional store merging into the newest entry: define WB_MERGE_EN.
module mips_cache_wbuf_fifo
   import mips_cache_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic        write_en,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   input  logic        active,
   input  logic        waitrequest,
   output logic        addr_in_wb,
   output logic [31:0] write_addr,
   output logic [31:0] write_data,
   output logic [3:0]  write_byteenable,
   output logic        write_writeenable,
   output logic [1:0]  state_out,
   output logic        full,
   output logic        empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wb_state_t            state, state_nxt;
   logic [PW-1:0]        head, tail, newest;
   logic [CW-1:0]        count;
   wb_entry_t            mem [DEPTH];
   wb_entry_t            head_e;
   logic [DEPTH-1:0]     valid;
   logic [DEPTH-1:0][29:0] entry_addr;
   logic [PW-1:0]        offs;
   logic                 newest_hit;
   logic                 retire, alloc, merge;
   logic                 unused_addr_lsb;

   assign unused_addr_lsb = &{1'b0, addr[1:0]};

   assign head_e = mem[head];
   assign newest = tail - PW'(1);
   assign full   = (count == CW'(DEPTH));
   assign empty  = (count == '0);
   assign retire = (state == ISSUE) && !waitrequest;

`ifdef WB_MERGE_EN
   // A head already on the bus must not change under the Avalon write.
   assign merge = write_en && newest_hit && !((state == ISSUE) && (count == CW'(1)));
`else
   logic unused_newest_hit;
   assign unused_newest_hit = newest_hit;
   assign merge = 1'b0;
`endif

   assign alloc = write_en && !merge && (!full || retire);

   // Entry i is live when its distance from head is below count.
   always_comb begin
      valid = '0;
      offs  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offs          = PW'(i) - head;
         valid[i]      = ({1'b0, offs} < count);
         entry_addr[i] = mem[i].addr;
      end
   end

   mips_cache_wbuf_match #(.DEPTH(DEPTH)) u_match (
      .req_addr   (addr[31:2]),
      .entry_addr (entry_addr),
      .valid      (valid),
      .newest     (newest),
      .hit        (addr_in_wb),
      .newest_hit (newest_hit)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         state <= state_nxt;
         if (retire) head <= head + PW'(1);
         if (alloc)  tail <= tail + PW'(1);
         case ({alloc, retire})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage carries no reset; validity comes from head/count.
   always_ff @(posedge clk) begin
      if (alloc) begin
         mem[tail] <= '{addr: addr[31:2], data: writedata, byteenable: byteenable};
      end
`ifdef WB_MERGE_EN
      else if (merge) begin
         for (int b = 0; b < 4; b++) begin
            if (byteenable[b]) mem[newest].data[8*b +: 8] <= writedata[8*b +: 8];
         end
         mem[newest].byteenable <= mem[newest].byteenable | byteenable;
      end
`endif
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (active && !empty) state_nxt = ISSUE;
         ISSUE:   if (retire) state_nxt = (count > CW'(1) && active) ? ISSUE : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      write_writeenable = 1'b0;
      write_addr        = '0;
      write_data        = '0;
      write_byteenable  = '0;
      if (state == ISSUE) begin
         write_writeenable = 1'b1;
         write_addr        = {head_e.addr, 2'b00};
         write_data        = head_e.data;
         write_byteenable  = head_e.byteenable;
      end
   end

   assign state_out = state;

endmodule

// File: tb/tb_mips_cache_wbuf_fifo.sv
// Directed self-checking bench for mips_cache_wbuf_fifo (DEPTH=4).
module tb_mips_cache_wbuf_fifo;

   logic        clk;
   logic        rst;
   logic [31:0] addr;
   logic        write_en;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic        active;
   logic        waitrequest;
   logic        addr_in_wb;
   logic [31:0] write_addr;
   logic [31:0] write_data;
   logic [3:0]  write_byteenable;
   logic        write_writeenable;
   logic [1:0]  state_out;
   logic        full;
   logic        empty;

   int tests_run = 0;
   int fails     = 0;

   mips_cache_wbuf_fifo #(.DEPTH(4)) dut (
      .clk               (clk),
      .rst               (rst),
      .addr              (addr),
      .write_en          (write_en),
      .writedata         (writedata),
      .byteenable        (byteenable),
      .active            (active),
      .waitrequest       (waitrequest),
      .addr_in_wb        (addr_in_wb),
      .write_addr        (write_addr),
      .write_data        (write_data),
      .write_byteenable  (write_byteenable),
      .write_writeenable (write_writeenable),
      .state_out         (state_out),
      .full              (full),
      .empty             (empty)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // Stimulus only: one store captured on the next rising edge.
   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      addr = a; writedata = d; byteenable = b; write_en = 1'b1;
      @(negedge clk);
      write_en = 1'b0;
      #1;
   endtask

   task automatic test_reset;
      tests_run++;
      if ({write_writeenable, write_addr, write_data, write_byteenable} !== {1'b0, 32'h0, 32'h0, 4'h0}) begin
         fails++;
         $display("FAIL reset_bus got we=%b a=%h d=%h be=%b want all zero",
                  write_writeenable, write_addr, write_data, write_byteenable);
      end
      tests_run++;
      if ({addr_in_wb, full, empty, state_out} !== {1'b0, 1'b0, 1'b1, 2'd0}) begin
         fails++;
         $display("FAIL reset_flags got hit=%b full=%b empty=%b st=%0d want 0 0 1 0",
                  addr_in_wb, full, empty, state_out);
      end
   endtask

   task automatic test_single;
      active = 1'b0; waitrequest = 1'b0;
      store(32'h1000_0007, 32'hDEAD_BEEF, 4'b1111);
      addr = 32'h1000_0004; #1;
      tests_run++;
      if ({empty, addr_in_wb} !== 2'b01) begin
         fails++;
         $display("FAIL single_enq got empty=%b hit=%b want 0 1", empty, addr_in_wb);
      end
      active = 1'b1; #1;
      tests_run++;
      if (write_writeenable !== 1'b0) begin
         fails++;
         $display("FAIL single_latency got we=%b want 0", write_writeenable);
      end
      @(negedge clk); #1;
      tests_run++;
      if ({write_writeenable, write_addr, write_data, write_byteenable} !== {1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF}) begin
         fails++;
         $display("FAIL single_issue got we=%b a=%h d=%h be=%b want 1 10000004 deadbeef 1111",
                  write_writeenable, write_addr, write_data, write_byteenable);
      end
      @(negedge clk); #1;
      tests_run++;
      if ({empty, write_writeenable, state_out} !== {1'b1, 1'b0, 2'd0}) begin
         fails++;
         $display("FAIL single_retire got empty=%b we=%b st=%0d want 1 0 0",
                  empty, write_writeenable, state_out);
      end
      active = 1'b0;
   endtask

   task automatic test_fill;
      active = 1'b0; waitrequest = 1'b0;
      for (int i = 0; i < 4; i++) begin
         store(32'(i + 1) * 32'h10, 32'(i + 1) * 32'h11, 4'hF);
         if (i == 2) begin
            tests_run++;
            if (full !== 1'b0) begin
               fails++;
               $display("FAIL fill_3 got full=%b want 0", full);
            end
         end
      end
      tests_run++;
      if ({full, empty} !== 2'b10) begin
         fails++;
         $display("FAIL fill_4 got full=%b empty=%b want 1 0", full, empty);
      end
      addr = 32'h30; #1;
      tests_run++;
      if (addr_in_wb !== 1'b1) begin
         fails++;
         $display("FAIL fill_hit30 got %b want 1", addr_in_wb);
      end
      addr = 32'h50; #1;
      tests_run++;
      if (addr_in_wb !== 1'b0) begin
         fails++;
         $display("FAIL fill_miss50 got %b want 0", addr_in_wb);
      end
      store(32'h50, 32'h55, 4'hF);
      addr = 32'h50; #1;
      tests_run++;
      if ({addr_in_wb, full} !== 2'b01) begin
         fails++;
         $display("FAIL fill_drop got hit=%b full=%b want 0 1", addr_in_wb, full);
      end
   endtask

   task automatic test_drain_wait;
      active = 1'b1; waitrequest = 1'b1;
      @(negedge clk); #1;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) begin
            waitrequest = 1'b0; #1;
         end
         tests_run++;
         if ({write_writeenable, write_addr, write_data, full} !== {1'b1, 32'h10, 32'h11, 1'b1}) begin
            fails++;
            $display("FAIL drain_hold%0d got we=%b a=%h d=%h full=%b want 1 10 11 1",
                     k, write_writeenable, write_addr, write_data, full);
         end
         @(negedge clk); #1;
      end
      tests_run++;
      if ({write_writeenable, write_addr, write_data, full} !== {1'b1, 32'h20, 32'h22, 1'b0}) begin
         fails++;
         $display("FAIL drain_20 got we=%b a=%h d=%h full=%b want 1 20 22 0",
                  write_writeenable, write_addr, write_data, full);
      end
      @(negedge clk); #1;
      tests_run++;
      if ({write_writeenable, write_addr, write_data} !== {1'b1, 32'h30, 32'h33}) begin
         fails++;
         $display("FAIL drain_30 got we=%b a=%h d=%h want 1 30 33",
                  write_writeenable, write_addr, write_data);
      end
      @(negedge clk); #1;
      tests_run++;
      if ({write_writeenable, write_addr, write_data} !== {1'b1, 32'h40, 32'h44}) begin
         fails++;
         $display("FAIL drain_40 got we=%b a=%h d=%h want 1 40 44",
                  write_writeenable, write_addr, write_data);
      end
      @(negedge clk); #1;
      tests_run++;
      if ({empty, write_writeenable, state_out} !== {1'b1, 1'b0, 2'd0}) begin
         fails++;
         $display("FAIL drain_done got empty=%b we=%b st=%0d want 1 0 0",
                  empty, write_writeenable, state_out);
      end
      active = 1'b0;
   endtask

   task automatic test_back_to_back;
      active = 1'b0; waitrequest = 1'b0;
      store(32'hA0, 32'hA, 4'hF);
      store(32'hB0, 32'hB, 4'hF);
      active = 1'b1;
      @(negedge clk); #1;
      tests_run++;
      if ({write_writeenable, write_addr, write_data} !== {1'b1, 32'hA0, 32'hA}) begin
         fails++;
         $display("FAIL b2b_a0 got we=%b a=%h d=%h want 1 a0 a",
                  write_writeenable, write_addr, write_data);
      end
      store(32'hC0, 32'hC, 4'hF);
      tests_run++;
      if ({write_writeenable, write_addr, write_data, full, empty} !== {1'b1, 32'hB0, 32'hB, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL b2b_b0 got we=%b a=%h d=%h full=%b empty=%b want 1 b0 b 0 0",
                  write_writeenable, write_addr, write_data, full, empty);
      end
      addr = 32'hC0; #1;
      tests_run++;
      if (addr_in_wb !== 1'b1) begin
         fails++;
         $display("FAIL b2b_hitc0 got %b want 1", addr_in_wb);
      end
      addr = 32'hA0; #1;
      tests_run++;
      if (addr_in_wb !== 1'b0) begin
         fails++;
         $display("FAIL b2b_missa0 got %b want 0", addr_in_wb);
      end
      @(negedge clk); #1;
      tests_run++;
      if ({write_writeenable, write_addr, write_data} !== {1'b1, 32'hC0, 32'hC}) begin
         fails++;
         $display("FAIL b2b_c0 got we=%b a=%h d=%h want 1 c0 c",
                  write_writeenable, write_addr, write_data);
      end
      @(negedge clk); #1;
      tests_run++;
      if ({empty, state_out} !== {1'b1, 2'd0}) begin
         fails++;
         $display("FAIL b2b_done got empty=%b st=%0d want 1 0", empty, state_out);
      end
      active = 1'b0;
   endtask

   task automatic test_merge;
      active = 1'b0; waitrequest = 1'b0;
      store(32'h80, 32'h0000_00AA, 4'b0001);
      store(32'h80, 32'h00CC_0000, 4'b0100);
      active = 1'b1;
      @(negedge clk); #1;
`ifdef WB_MERGE_EN
      tests_run++;
      if ({write_writeenable, write_addr, write_data, write_byteenable} !== {1'b1, 32'h80, 32'h00CC_00AA, 4'b0101}) begin
         fails++;
         $display("FAIL merge_entry got we=%b a=%h d=%h be=%b want 1 80 00cc00aa 0101",
                  write_writeenable, write_addr, write_data, write_byteenable);
      end
`else
      tests_run++;
      if ({write_writeenable, write_addr, write_data, write_byteenable} !== {1'b1, 32'h80, 32'h0000_00AA, 4'b0001}) begin
         fails++;
         $display("FAIL nomerge_first got we=%b a=%h d=%h be=%b want 1 80 000000aa 0001",
                  write_writeenable, write_addr, write_data, write_byteenable);
      end
      @(negedge clk); #1;
      tests_run++;
      if ({write_writeenable, write_addr, write_data, write_byteenable} !== {1'b1, 32'h80, 32'h00CC_0000, 4'b0100}) begin
         fails++;
         $display("FAIL nomerge_second got we=%b a=%h d=%h be=%b want 1 80 00cc0000 0100",
                  write_writeenable, write_addr, write_data, write_byteenable);
      end
`endif
      @(negedge clk); #1;
      tests_run++;
      if ({empty, write_writeenable} !== 2'b10) begin
         fails++;
         $display("FAIL merge_done got empty=%b we=%b want 1 0", empty, write_writeenable);
      end
      active = 1'b0;
   endtask

   task automatic test_reset_mid_issue;
      active = 1'b0; waitrequest = 1'b1;
      store(32'h200, 32'h2, 4'hF);
      active = 1'b1;
      @(negedge clk); #1;
      tests_run++;
      if ({write_writeenable, write_addr} !== {1'b1, 32'h200}) begin
         fails++;
         $display("FAIL rstmid_issue got we=%b a=%h want 1 200", write_writeenable, write_addr);
      end
      addr = 32'h200;
      rst  = 1'b0; #1;
      tests_run++;
      if ({write_writeenable, empty, state_out, addr_in_wb, full} !== {1'b0, 1'b1, 2'd0, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL rstmid_async got we=%b empty=%b st=%0d hit=%b full=%b want 0 1 0 0 0",
                  write_writeenable, empty, state_out, addr_in_wb, full);
      end
      @(negedge clk);
      rst = 1'b1; waitrequest = 1'b0; #1;
      @(negedge clk); #1;
      tests_run++;
      if ({empty, write_writeenable} !== 2'b10) begin
         fails++;
         $display("FAIL rstmid_after got empty=%b we=%b want 1 0", empty, write_writeenable);
      end
      active = 1'b0;
   endtask

   initial begin
      rst = 1'b0; addr = '0; write_en = 1'b0; writedata = '0; byteenable = '0;
      active = 1'b0; waitrequest = 1'b0;
      #1;
      test_reset;
      @(negedge clk); #1;
      rst = 1'b1;
      @(negedge clk); #1;
      test_single;
      test_fill;
      test_drain_wait;
      test_back_to_back;
      test_merge;
      test_reset_mid_issue;
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule

// File: doc/mips_cache_wbuf_fifo.md
# mips_cache_wbuf_fifo

Posted-write FIFO between the CPU data port and the Avalon bus, owned by the cache controller. It captures every data-side store, including its byte enables, and returns the CPU in one cycle. While the controller grants it the bus, it drains entries in order as Avalon writes. It also reports address hits so the controller does not fetch a word that is still waiting in the buffer.

## Interface
Parameters:
- DEPTH, 4: number of entries; must be a power of 2 and at least 2.

Ports:
- clk, in, 1: the single clock.
- rst, in, 1: reset, asynchronous, active-low.
- addr, in, 32: store byte address; bits [1:0] are ignored.
- write_en, in, 1: store request.
- writedata, in, 32: store data.
- byteenable, in, 4: store lane enables.
- active, in, 1: bus grant from the controller.
- waitrequest, in, 1: Avalon waitrequest.
- addr_in_wb, out, 1: addr[31:2] matches a valid entry.
- write_addr, out, 32: Avalon address, with [1:0] forced to 2'b00.
- write_data, out, 32: Avalon writedata.
- write_byteenable, out, 4: Avalon byteenable.
- write_writeenable, out, 1: Avalon write.
- state_out, out, 2: current drain state.
- full, out, 1: count equals DEPTH.
- empty, out, 1: count equals 0.

## Operation
- Storage is a circular buffer with head and tail pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Enqueue condition: write_en && (!full || retire). A write_en while full with no retire in the same cycle is dropped. The controller prevents this case by stalling on full.
- retire = write_writeenable && !waitrequest, evaluated at the clock edge.
- Simultaneous enqueue and retire leaves count unchanged. Both pointers advance.
- Drain state machine, with state_out encoding IDLE=0 and ISSUE=1:
  - IDLE -> ISSUE when active && !empty.
  - ISSUE -> ISSUE on retire if count > 1 and active is still high; the next head is presented back-to-back.
  - ISSUE -> IDLE on retire if count == 1 or active is low.
  - ISSUE holds while waitrequest is high, even if active drops. An Avalon write is never aborted.
- In ISSUE, write_writeenable is 1 and write_addr, write_data and write_byteenable come from the head entry. They stay stable while waitrequest is high.
- In IDLE, write_writeenable is 0 and write_addr, write_data and write_byteenable are 0.
- addr_in_wb is combinational over all valid entries, including the head being issued. It is 0 when empty.
- Reset:
  - Outputs: write_writeenable, write_addr, write_data, write_byteenable, addr_in_wb and full are 0; empty is 1; state_out is IDLE.
  - Internal: pointers and count are 0.
  - Asserting rst mid-ISSUE discards all entries immediately.

## Timing
- A store at edge N sets empty=0 after edge N. addr_in_wb reflects the new entry from cycle N+1.
- With active high, write_writeenable rises after edge N+1, giving 1 cycle of enqueue-to-bus latency.
- A sustained drain with waitrequest low retires one entry per cycle.
- full rises in the cycle after the DEPTH-th un-retired enqueue.
- full falls in the cycle after the first retire.

## Configuration
- Macro: WB_MERGE_EN.
- When WB_MERGE_EN is defined:
  - A store whose addr[31:2] equals the newest entry's address merges into that entry, unless that entry is the head in ISSUE.
  - Merging overwrites the lanes set in byteenable and ORs byteenable into the entry's enables.
  - count is unchanged, and a merge is allowed even when full.
- When WB_MERGE_EN is undefined, every accepted store allocates a new entry.

## Structure
- Shared package mips_cache_pkg holds:
  - the wb_state_t enum (IDLE, ISSUE);
  - the wb_entry_t struct (addr[31:2], data, byteenable).
  The controller imports the same state typedef.
- One sub-module is used: mips_cache_wbuf_match. It is a combinational DEPTH-way word-address comparator that produces addr_in_wb and the newest-entry hit used for merging.

## Test plan
- Reset with rst=0 mid-ISSUE, holding waitrequest=1 -> write_writeenable=0, empty=1 and state_out=0 immediately, before the next edge.
- Store addr=0x1000_0007, data=0xDEADBEEF, be=4'b1111, then active=1 with waitrequest low -> one cycle later write_writeenable=1, write_addr=0x1000_0004, write_data=0xDEADBEEF; empty=1 after the retire.
- 4 stores to 0x10, 0x20, 0x30 and 0x40 with active=0 (DEPTH=4) -> full=1 and addr_in_wb=1 for addr=0x30; a 5th store is dropped.
- Full FIFO, active=1, waitrequest=1 for 3 cycles, then 0 -> head 0x10 is held stable for 4 cycles, then 0x20, 0x30 and 0x40 drain on consecutive cycles.
- Simultaneous store and retire at count=2 -> count stays 2 and ordering is preserved.
- WB_MERGE_EN: store 0x80 with be=0001 and data=0x000000AA, then store 0x80 with be=0100 and data=0x00CC0000, with active=0 -> one entry with be=0101 and data=0x00CC00AA. Without WB_MERGE_EN -> two entries.
